sigma_delta_decimator: RTL and testbench



---
 rtl/sigma_delta_decimator.sv | 83 ++++++++
 tb/tb_sigma_delta_decimator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_decimator.sv
// Fifth-order CIC decimator (R = 64, M = 1) turning a 1-bit sigma-delta stream
// into 24-bit signed PCM with saturation after a fixed 7-bit arithmetic shift.
module sigma_delta_decimator #(
  parameter int CIC_ORDER = 5,
  parameter int DECIM     = 64,
  parameter int ACC_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               data_in,
  input  logic               data_valid,
  output logic signed [23:0] pcm_out,
  output logic               out_valid
);

  localparam int OUT_W = 24;
  localparam int SHIFT = 7;
  localparam int CNT_W = $clog2(DECIM);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -SAT_MAX - ACC_W'(1);

  logic signed [ACC_W-1:0] r_integ [CIC_ORDER];
  logic signed [ACC_W-1:0] r_dly   [CIC_ORDER];
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_dec;

  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W-1:0] w_comb [CIC_ORDER+1];
  logic signed [ACC_W-1:0] w_scaled;
  logic signed [OUT_W-1:0] w_pcm;

  // 1 -> +1 (0...01), 0 -> -1 (1...11)
  assign w_x = {{(ACC_W-1){~data_in}}, 1'b1};

  always_comb begin
    w_comb[0] = r_integ[CIC_ORDER-1];
    for (int unsigned k = 0; k < CIC_ORDER; k++) begin
      w_comb[k+1] = w_comb[k] - r_dly[k];
    end
    w_scaled = w_comb[CIC_ORDER] >>> SHIFT;
    if (w_scaled > SAT_MAX) begin
      w_pcm = SAT_MAX[OUT_W-1:0];
    end else if (w_scaled < SAT_MIN) begin
      w_pcm = SAT_MIN[OUT_W-1:0];
    end else begin
      w_pcm = w_scaled[OUT_W-1:0];
    end
  end

  // r_dec marks the edge after the decimation edge; the comb then sees the
  // freshly updated last integrator regardless of data_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < CIC_ORDER; k++) begin
        r_integ[k] <= '0;
        r_dly[k]   <= '0;
      end
      r_cnt     <= '0;
      r_dec     <= 1'b0;
      pcm_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= r_dec;
      r_dec     <= 1'b0;
      if (data_valid) begin
        r_integ[0] <= r_integ[0] + w_x;
        for (int unsigned k = 1; k < CIC_ORDER; k++) begin
          r_integ[k] <= r_integ[k] + r_integ[k-1];
        end
        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        r_dec <= (r_cnt == CNT_LAST);
      end
      if (r_dec) begin
        for (int unsigned k = 0; k < CIC_ORDER; k++) begin
          r_dly[k] <= w_comb[k];
        end
        pcm_out <= w_pcm;
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Bench for sigma_delta_decimator: directed patterns and random streams checked
// against a convolution model built from the CIC impulse response.
module tb_sigma_delta_decimator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               data_in;
  logic               data_valid;
  logic signed [23:0] pcm_out;
  logic               out_valid;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  longint h[];
  int     xs[$];

  logic               exp_ov;
  logic signed [23:0] exp_pcm;
  logic               pend;
  logic signed [23:0] pend_val;

  sigma_delta_decimator #(
    .CIC_ORDER(5),
    .DECIM    (64),
    .ACC_W    (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .pcm_out   (pcm_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Overall response: z^-4 (registered integrator chain) times five 64-tap boxcars.
  task automatic build_h();
    longint t[];
    h = new[1];
    h[0] = 1;
    repeat (5) begin
      t = new[h.size() + 63];
      foreach (t[i]) t[i] = 0;
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < 64; j++)
          t[i+j] += h[i];
      h = t;
    end
  endtask

  function automatic logic signed [23:0] model_pcm();
    longint y = 0;
    longint s;
    int n = xs.size();
    for (int d = 0; d < h.size(); d++) begin
      int idx = n - 4 - d;
      if (idx >= 1) y += h[d] * longint'(xs[idx-1]);
    end
    s = y >>> 7;
    if (s > 64'sd8388607) s = 64'sd8388607;
    else if (s < -64'sd8388608) s = -64'sd8388608;
    return 24'(s);
  endfunction

  task automatic chk_bit(input string tag, input logic got, input logic want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  task automatic chk_pcm(input string tag, input logic signed [23:0] got,
                         input logic signed [23:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step(input logic d, input logic v);
    @(negedge clk);
    data_in    = d;
    data_valid = v;
    @(posedge clk);
    #1;
    if (pend) begin
      exp_ov  = 1'b1;
      exp_pcm = pend_val;
      pend    = 1'b0;
    end else begin
      exp_ov = 1'b0;
    end
    chk_bit("out_valid", out_valid, exp_ov);
    chk_pcm("pcm_out", pcm_out, exp_pcm);
    if (out_valid === 1'b1) pulses++;
    if (v) begin
      xs.push_back(d ? 1 : -1);
      if (xs.size() % 64 == 0) begin
        pend     = 1'b1;
        pend_val = model_pcm();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    #1;
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_pcm("rst_pcm_out", pcm_out, 24'sd0);
    xs.delete();
    pend    = 1'b0;
    exp_ov  = 1'b0;
    exp_pcm = '0;
    pulses  = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_pat(input logic [3:0] pat, input int plen, input int nacc,
                         input bit gaps);
    for (int i = 0; i < nacc; i++) begin
      if (gaps) step(1'($urandom), 1'b0);
      step(pat[2'(i % plen)], 1'b1);
    end
    repeat (3) step(1'b0, 1'b0);
  endtask

  task automatic run_rand(input int nacc, input int gap_pct);
    int acc = 0;
    while (acc < nacc) begin
      logic v;
      v = (($urandom % 100) >= gap_pct);
      step(1'($urandom), v);
      if (v) acc++;
    end
    repeat (3) step(1'b0, 1'b0);
  endtask

  initial begin
    build_h();
    rst_n      = 1'b0;
    data_in    = 1'b0;
    data_valid = 1'b0;
    pend       = 1'b0;
    exp_ov     = 1'b0;
    exp_pcm    = '0;
    #1;
    chk_bit("init_out_valid", out_valid, 1'b0);
    chk_pcm("init_pcm_out", pcm_out, 24'sd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_pat(4'b0001, 1, 1024, 1'b0);
    chk_pcm("ones_settled", pcm_out, 24'sd8388607);
    chk_int("ones_pulses", pulses, 16);

    do_reset();
    run_pat(4'b0000, 1, 1024, 1'b0);
    chk_pcm("zeros_settled", pcm_out, -24'sd8388608);

    do_reset();
    run_pat(4'b0001, 2, 1024, 1'b0);
    chk_pcm("alt_settled", pcm_out, 24'sd0);

    do_reset();
    run_pat(4'b0111, 4, 1024, 1'b0);
    chk_pcm("p1110_settled", pcm_out, 24'sd4194304);

    do_reset();
    run_pat(4'b0001, 4, 1024, 1'b0);
    chk_pcm("p1000_settled", pcm_out, -24'sd4194304);

    do_reset();
    run_pat(4'b0111, 4, 1024, 1'b1);
    chk_pcm("gaps_settled", pcm_out, 24'sd4194304);
    chk_int("gaps_pulses", pulses, 16);

    // Partial frame of 30 bits, then reset while pcm_out holds a non-zero value.
    for (int i = 0; i < 30; i++) step(1'($urandom), 1'b1);
    do_reset();
    for (int i = 0; i < 64; i++) step(1'($urandom), 1'b1);
    chk_int("midrst_no_early_pulse", pulses, 0);
    step(1'b0, 1'b0);
    chk_int("midrst_pulse_after_64", pulses, 1);

    do_reset();
    run_rand(64 * 12, 0);
    chk_int("rand_pulses", pulses, 12);

    do_reset();
    run_rand(64 * 12, 40);
    chk_int("rand_gap_pulses", pulses, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
